// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// datapath widths and small PC helper functions.
package fetch_unit_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        S_START = 2'b00,
        S_FETCH = 2'b01,
        S_HOLD  = 2'b10
    } state_e;

    // Sequential fetch address; the add wraps naturally modulo 2^32.
    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(PC_STEP);
    endfunction

    // Force a redirect target onto a word boundary.
    function automatic logic [ADDR_W-1:0] pc_align(input logic [ADDR_W-1:0] pc);
        return pc & ~ADDR_W'(PC_STEP - 1);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Issues sequential word fetches to instruction
// memory, registers the returned word for decode, holds it while decode
// stalls and redirects on a taken branch.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   PCSrc, exNPC           branch-taken redirect and its target
//   stall                  decode cannot take a new instruction
//   imem_req, imem_addr    fetch request / byte address to memory
//   imem_ready, imem_rdata memory accept and same-cycle read data
//   instr, instr_valid, PC registered instruction, live flag and its address
//
// Build option: define FETCH_PERF_EN to add the fetch_count and
// redirect_count performance counter outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  exNPC,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  PC
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        redirect_count
`endif
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fpc_q, fpc_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                valid_q, valid_d;

    logic                hold_c;
    logic                req_c;
    logic                accept_c;

    // A live instruction that decode cannot take blocks any new fetch, so
    // the request is withdrawn in the same cycle the stall is seen.
    assign hold_c   = valid_q & stall;
    assign req_c    = (state_q == S_FETCH) & ~hold_c;
    assign accept_c = req_c & imem_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
            fpc_q   <= RESET_PC;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and datapath update; redirect overrides stall, which
    // overrides accept.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;

        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: state_d = hold_c ? S_HOLD : S_FETCH;
            S_HOLD:  state_d = stall ? S_HOLD : S_FETCH;
            default: state_d = S_START;
        endcase

        // Without a stall decode consumes the current word, so it stops
        // being live unless a new word replaces it this cycle.
        if (!hold_c) begin
            valid_d = 1'b0;
        end

        if (accept_c) begin
            instr_d = imem_rdata;
            pc_d    = fpc_q;
            valid_d = 1'b1;
            fpc_d   = pc_next(fpc_q);
        end

        // Redirect drops any coincident accept and flushes the live word.
        if (PCSrc) begin
            state_d = S_FETCH;
            fpc_d   = pc_align(exNPC);
            pc_d    = pc_q;
            instr_d = instr_q;
            valid_d = 1'b0;
        end
    end

    assign imem_req    = req_c;
    assign imem_addr   = fpc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign PC          = pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] redirect_cnt_q;

    // Performance counters: kept fetches and redirect cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (accept_c && !PCSrc) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (PCSrc) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count    = fetch_cnt_q;
    assign redirect_count = redirect_cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset (bits [1:0] SHALL be 0).
REQ-002 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port PCSrc  input  1  branch-taken redirect from branchlogic.
REQ-005 SHALL have port exNPC  input  32  redirect target from branchlogic.
REQ-006 SHALL have port stall  input  1  downstream cannot accept a new instruction.
REQ-007 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-008 SHALL have port imem_addr  output  32  fetch byte address.
REQ-009 SHALL have port imem_ready  input  1  memory accepts request; imem_rdata valid same cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have port instr  output  32  registered instruction to decode.
REQ-012 SHALL have port instr_valid  output  1  instr holds a live instruction.
REQ-013 SHALL have port PC  output  32  address of the instruction on instr (consumed by branchlogic).

Function
REQ-014 SHALL implement FSM states S_START, S_FETCH, S_HOLD.
REQ-015 S_START SHALL last exactly one cycle after rst_n deasserts, imem_req=0, then go to S_FETCH.
REQ-016 In S_FETCH imem_req SHALL be 1 and imem_addr SHALL equal internal fetch PC (fpc).
REQ-017 Accept = imem_req && imem_ready; on accept, next edge: instr<=imem_rdata, PC<=fpc, instr_valid<=1, fpc<=fpc+4.
REQ-018 fpc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-019 If instr_valid=1 and stall=1, FSM SHALL be in S_HOLD: imem_req=0, instr/PC/instr_valid/fpc held.
REQ-020 S_HOLD SHALL return to S_FETCH in the cycle after stall drops; no instruction lost or duplicated.
REQ-021 PCSrc=1 SHALL, next edge: fpc<={exNPC[31:2],2'b00}, instr_valid<=0, state<=S_FETCH.
REQ-022 Priority SHALL be redirect > stall > accept; an accept coinciding with PCSrc=1 SHALL be discarded.
REQ-023 PCSrc=1 during S_START SHALL still load fpc from exNPC.
REQ-024 With imem_ready=0, S_FETCH SHALL hold imem_req=1 and imem_addr stable until accept or redirect.
REQ-025 Fetch-to-instr latency SHALL be one cycle from accept; sustained throughput one instruction/cycle with imem_ready=1, stall=0.

Reset
REQ-026 On rst_n=0 SHALL asynchronously set: state=S_START, fpc=RESET_PC, PC=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0.
REQ-027 Reset asserted mid-request SHALL abandon it; no instr update from that request.

Configuration
REQ-028 Macro FETCH_PERF_EN SHALL, when defined, add outputs fetch_count[31:0] (accepted, non-discarded fetches) and redirect_count[31:0] (cycles with PCSrc=1), both reset to 0, wrapping at 2^32.
REQ-029 Without FETCH_PERF_EN SHALL have neither ports nor counter logic; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold FSM state encoding (2-bit S_START/S_FETCH/S_HOLD), INSTR_W=32, PC_STEP=4.
REQ-031 Single module, no sub-modules; the counters under FETCH_PERF_EN stay inline.

Verification
REQ-032 Reset, RESET_PC=0, imem_ready=1, stall=0 -> imem_addr 0,4,8,...; instr_valid=1 from 2nd cycle after reset release, PC trails imem_addr by one cycle.
REQ-033 imem_ready low 3 cycles at addr 0x10 -> imem_req=1, addr 0x10 held; instr updates once, one cycle after ready rises.
REQ-034 stall=1 for 2 cycles with PC=0x8 -> PC/instr frozen, imem_req=0; next accept fetches 0xC, no skip/duplicate.
REQ-035 PCSrc=1, exNPC=0x0000_0103 coincident with accept -> instr_valid=0 next cycle, next imem_addr=0x100, accepted word discarded.
REQ-036 fpc=0xFFFF_FFFC accepted -> next imem_addr=0x0.
REQ-037 With FETCH_PERF_EN, 5 accepts + 1 redirect (1 accept discarded) -> fetch_count=4, redirect_count=1.
